// File: rtl/risc_v_multicycle_controller.sv
// Multicycle RV32 control FSM: Moore-decoded datapath controls, memory states stall on mem_ready.
// Instruction latency 3..5 cycles plus one per mem_ready=0 cycle; reset forces every output low.
module risc_v_multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_JALR2    = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    function automatic logic [2:0] imm_for(input logic [6:0] o);
        case (o)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_for = IMM_I;
            OP_STORE:                   imm_for = IMM_S;
            OP_BRANCH:                  imm_for = IMM_B;
            OP_JAL:                     imm_for = IMM_J;
            OP_LUI:                     imm_for = IMM_U;
            default:                    imm_for = IMM_I;
        endcase
    endfunction

    // sub_ok is low for immediates: IR[30] is part of the immediate there.
    function automatic logic [2:0] alu_for(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  alu_for = sub_ok ? ALU_SUB : ALU_ADD;
            3'b111:  alu_for = ALU_AND;
            3'b110:  alu_for = ALU_OR;
            3'b010:  alu_for = ALU_SLT;
            default: alu_for = ALU_ADD;
        endcase
    endfunction

    logic [3:0] state_q;
    logic [3:0] state_nxt;
    logic       taken;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_nxt;
    end

    always_comb begin
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_LUI:            state_nxt = S_LUI;
                    default:           state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_JALR2, S_LUI: state_nxt = S_ALUWB;
            S_JALR:     state_nxt = S_JALR2;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // All decoding sits under rst so nothing, strobe or mux select, leaks out during reset.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        illegal     = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = imm_for(op);
                    illegal   = (state_nxt == S_FETCH);
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = imm_for(op);
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = alu_for(func3, func7);
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = alu_for(func3, 1'b0);
                end
                S_ALUWB:  reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = ALU_SUB;
                    pc_write    = taken;
                end
                S_JAL, S_JALR2: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                end
                default: ;
            endcase
        end
    end

endmodule
